// File: rtl/i2s_rx_capture.sv
`timescale 1ns/1ps
// I2S receiver: deserialises 16-bit stereo samples from an async codec interface and
// packs four stereo frames into one 128-bit SDRAM line written via a request/ack port.
module i2s_rx_capture #(
    parameter int unsigned SAMPLE_BITS = 16,
    parameter logic [21:0] BASE_ADDR   = 22'h200000,
    parameter logic [21:0] NUM_LINES   = 22'h010000,
    parameter bit          WRAP        = 1'b1
) (
    input  logic         Clk50,
    input  logic         reset,
    input  logic         enable,
    input  logic         LRClk,
    input  logic         SClk,
    input  logic         Din,
    output logic         sdram_wr,
    output logic [21:0]  sdram_addr,
    output logic [127:0] sdram_data,
    input  logic         sdram_ac,
    output logic         busy,
    output logic         overflow,
    output logic [21:0]  lines_written,
    output logic         capture_done,
    output logic [1:0]   dbg_cap_state_o,
    output logic         dbg_wr_state_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_L = 2'd1, CAP = 2'd2} cap_state_e;
    typedef enum logic {W_IDLE = 1'b0, W_REQ = 1'b1} wr_state_e;

    localparam logic [3:0]  LAST_BIT  = 4'(SAMPLE_BITS - 1);
    localparam logic [21:0] LAST_ADDR = BASE_ADDR + NUM_LINES - 22'd1;

    logic [1:0]   lr_sync_q;
    logic [1:0]   din_sync_q;
    logic [2:0]   sclk_sync_q;
    logic         lr_prev_q;
    logic         sclk_rise, lr_now, din_now, lr_edge, lr_fall, slot_start;
    logic [15:0]  sample_next;

    cap_state_e   cap_q, cap_d;
    wr_state_e    wr_q, wr_d;
    logic         active_q;
    logic [3:0]   bit_cnt_q;
    logic [15:0]  shift_q;
    logic [2:0]   k_q;
    logic [127:0] line_q;
    logic         handoff_q;
    logic         pend_q;
    logic [127:0] pend_data_q;
    logic [21:0]  addr_q, lines_q;
    logic         overflow_q, done_q;
    logic         ack, last_line;

    // Synchronisers carry no reset so the LRClk history stays valid across a reset pulse.
    always_ff @(posedge Clk50) begin
        lr_sync_q   <= {lr_sync_q[0], LRClk};
        din_sync_q  <= {din_sync_q[0], Din};
        sclk_sync_q <= {sclk_sync_q[1:0], SClk};
        if (sclk_rise) lr_prev_q <= lr_now;
    end

    assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign lr_now      = lr_sync_q[1];
    assign din_now     = din_sync_q[1];
    assign lr_edge     = sclk_rise & (lr_now != lr_prev_q);
    assign lr_fall     = lr_edge & ~lr_now;
    assign slot_start  = ((cap_q == WAIT_L) && lr_fall) || ((cap_q == CAP) && lr_edge);
    assign sample_next = {shift_q[14:0], din_now};

    always_comb begin
        cap_d = cap_q;
        unique case (cap_q)
            IDLE:    if (enable && !done_q) cap_d = WAIT_L;
            WAIT_L:  if (lr_fall) cap_d = CAP;
            CAP:     cap_d = CAP;
            default: cap_d = IDLE;
        endcase
        if (!enable || done_q) cap_d = IDLE;
    end

    // The sclk_rise that reveals a slot edge carries the I2S delay bit, so it only arms the slot.
    always_ff @(posedge Clk50) begin
        if (reset) begin
            cap_q     <= IDLE;
            active_q  <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            k_q       <= '0;
            line_q    <= '0;
            handoff_q <= 1'b0;
        end else begin
            cap_q     <= cap_d;
            handoff_q <= 1'b0;
            if (cap_d == IDLE) begin
                active_q <= 1'b0;
                k_q      <= '0;
            end else if (slot_start) begin
                active_q  <= 1'b1;
                bit_cnt_q <= '0;
                shift_q   <= '0;
            end else if ((cap_q == CAP) && sclk_rise && active_q) begin
                shift_q   <= sample_next;
                bit_cnt_q <= bit_cnt_q + 4'd1;
                if (bit_cnt_q == LAST_BIT) begin
                    active_q               <= 1'b0;
                    line_q[16*k_q +: 16]   <= sample_next;
                    k_q                    <= k_q + 3'd1;
                    if (k_q == 3'd7) handoff_q <= 1'b1;
                end
            end
        end
    end

    // sdram_wr/sdram_ac: a request holds addr/data stable until a one-cycle ack; an ack
    // with no request is ignored, and the request drops for at least one cycle after an ack.
    assign ack       = (wr_q == W_REQ) && sdram_ac;
    assign last_line = !WRAP && (lines_q == NUM_LINES - 22'd1);

    always_comb begin
        wr_d = wr_q;
        unique case (wr_q)
            W_IDLE:  if (pend_q && !done_q) wr_d = W_REQ;
            W_REQ:   if (ack) wr_d = W_IDLE;
            default: wr_d = W_IDLE;
        endcase
    end

    always_ff @(posedge Clk50) begin
        if (reset) begin
            wr_q        <= W_IDLE;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            addr_q      <= BASE_ADDR;
            lines_q     <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wr_q <= wr_d;
            if (ack) begin
                lines_q <= lines_q + 22'd1;
                addr_q  <= (WRAP && (addr_q == LAST_ADDR)) ? BASE_ADDR : addr_q + 22'd1;
                if (last_line) done_q <= 1'b1;
            end
            // An ack in the hand-off cycle frees the slot in time for the new line.
            if (handoff_q && !done_q && !(ack && last_line)) begin
                if (!pend_q || ack) begin
                    pend_q      <= 1'b1;
                    pend_data_q <= line_q;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (ack) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign sdram_wr        = (wr_q == W_REQ);
    assign sdram_addr      = addr_q;
    assign sdram_data      = pend_data_q;
    assign busy            = (cap_q != IDLE) || (wr_q == W_REQ);
    assign overflow        = overflow_q;
    assign lines_written   = lines_q;
    assign capture_done    = done_q;
    assign dbg_cap_state_o = cap_q;
    assign dbg_wr_state_o  = wr_q;

endmodule

// File: tb/tb_i2s_rx_capture.sv
`timescale 1ns/1ps
// Bench for i2s_rx_capture: a wrapping instance (NUM_LINES=2) and a stop-at-end instance
// share one I2S stream; accepted writes are scored against an expected-line queue.
module tb_i2s_rx_capture;

    localparam logic [21:0] BASE = 22'h200000;

    logic         clk50 = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         en_nw = 1'b0;
    logic         lrclk = 1'b1;
    logic         sclk = 1'b1;
    logic         din = 1'b0;
    logic         ac = 1'b0;
    logic         ac_nw = 1'b0;
    logic         ack_hold = 1'b0;
    int           ack_cnt = 0;
    int           ack_cnt_nw = 0;

    logic         sdram_wr, wr_nw;
    logic [21:0]  sdram_addr, addr_nw;
    logic [127:0] sdram_data, data_nw;
    logic         busy, busy_nw, overflow, ovf_nw, capture_done, done_nw;
    logic [21:0]  lines_written, lw_nw;
    logic [1:0]   dbg_cap, dbg_cap_nw;
    logic         dbg_wr, dbg_wr_nw;

    int           total = 0;
    int           bad = 0;
    logic [149:0] exp_q[$];
    logic [149:0] got_q[$];
    logic [149:0] exp_nw_q[$];
    logic [149:0] got_nw_q[$];

    i2s_rx_capture #(.WRAP(1'b1), .NUM_LINES(22'd2)) dut (
        .Clk50(clk50), .reset(reset), .enable(enable), .LRClk(lrclk), .SClk(sclk), .Din(din),
        .sdram_wr(sdram_wr), .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_ac(ac),
        .busy(busy), .overflow(overflow), .lines_written(lines_written),
        .capture_done(capture_done), .dbg_cap_state_o(dbg_cap), .dbg_wr_state_o(dbg_wr)
    );

    i2s_rx_capture #(.WRAP(1'b0), .NUM_LINES(22'd2)) dut_nw (
        .Clk50(clk50), .reset(reset), .enable(en_nw), .LRClk(lrclk), .SClk(sclk), .Din(din),
        .sdram_wr(wr_nw), .sdram_addr(addr_nw), .sdram_data(data_nw), .sdram_ac(ac_nw),
        .busy(busy_nw), .overflow(ovf_nw), .lines_written(lw_nw),
        .capture_done(done_nw), .dbg_cap_state_o(dbg_cap_nw), .dbg_wr_state_o(dbg_wr_nw)
    );

    // clock / reset
    always #10 clk50 = ~clk50;

    initial begin
        #3ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // arbiters: ack a few cycles after a request, unless held off
    initial begin
        forever begin
            @(posedge clk50);
            #1;
            ac = 1'b0;
            if (sdram_wr && !ack_hold) begin
                if (ack_cnt >= 4) begin ac = 1'b1; ack_cnt = 0; end
                else ack_cnt++;
            end else ack_cnt = 0;
            ac_nw = 1'b0;
            if (wr_nw) begin
                if (ack_cnt_nw >= 2) begin ac_nw = 1'b1; ack_cnt_nw = 0; end
                else ack_cnt_nw++;
            end else ack_cnt_nw = 0;
        end
    end

    // record accepted writes
    initial begin
        forever begin
            @(negedge clk50);
            if (sdram_wr && ac) got_q.push_back({sdram_addr, sdram_data});
            if (wr_nw && ac_nw) got_nw_q.push_back({addr_nw, data_nw});
        end
    end

    // driver tasks: 320 ns SClk, data/LRClk change after the falling edge
    task automatic i2s_bit(input logic lr, input logic d);
        sclk = 1'b0;
        #80;
        lrclk = lr;
        din = d;
        #80;
        sclk = 1'b1;
        #160;
    endtask

    task automatic i2s_slot(input logic lr, input logic [15:0] s, input logic pad);
        i2s_bit(lr, pad);
        for (int i = 15; i >= 0; i--) i2s_bit(lr, s[i]);
        for (int i = 0; i < 15; i++) i2s_bit(lr, 1'($urandom_range(0, 1)));
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input logic pad);
        i2s_slot(1'b0, l, pad);
        i2s_slot(1'b1, r, pad);
    endtask

    task automatic send_line(input logic [127:0] line, input logic pad);
        for (int f = 0; f < 4; f++) send_frame(line[32*f +: 16], line[32*f+16 +: 16], pad);
    endtask

    task automatic wait_got(input int max_cycles, output bit ok);
        for (int i = 0; i < max_cycles && got_q.size() == 0; i++) @(negedge clk50);
        ok = (got_q.size() > 0);
    endtask

    task automatic pulse_reset();
        enable = 1'b0;
        en_nw = 1'b0;
        @(negedge clk50);
        reset = 1'b1;
        repeat (3) @(negedge clk50);
        reset = 1'b0;
        exp_q.delete();
        got_q.delete();
        exp_nw_q.delete();
        got_nw_q.delete();
    endtask

    // scenarios
    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) i2s_bit(1'b1, 1'b0);
        @(negedge clk50);
        total++; if (sdram_wr !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b exp=0", sdram_wr); end
        total++; if (sdram_addr !== BASE) begin bad++; $display("FAIL reset_addr got=%h exp=%h", sdram_addr, BASE); end
        total++; if (sdram_data !== 128'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", sdram_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        total++; if (lines_written !== 22'd0) begin bad++; $display("FAIL reset_lines got=%0d exp=0", lines_written); end
        total++; if (capture_done !== 1'b0 || done_nw !== 1'b0) begin bad++; $display("FAIL reset_done got=%b%b exp=00", capture_done, done_nw); end
        reset = 1'b0;
    endtask

    task automatic test_basic_line();
        logic [127:0] line;
        logic [149:0] got, exp;
        bit ok;
        line = 128'h88887777666655554444333322221111;
        pulse_reset();
        enable = 1'b1;
        exp_q.push_back({BASE, line});
        send_line(line, 1'($urandom_range(0, 1)));
        wait_got(200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_write got=none exp=%h", exp_q[0]); end
        else begin
            got = got_q.pop_front(); exp = exp_q.pop_front();
            if (got !== exp) begin bad++; $display("FAIL basic_write got=%h exp=%h", got, exp); end
        end
        total++; if (lines_written !== 22'd1) begin bad++; $display("FAIL basic_lines got=%0d exp=1", lines_written); end
    endtask

    task automatic test_enable_mid_slot();
        logic [127:0] line;
        logic [149:0] got, exp;
        bit ok;
        line = 128'h7ffe_0180_4002_1ff8_a5a5_3c3c_0001_8001;
        pulse_reset();
        fork
            send_frame(16'h5a5a, 16'hc3c3, 1'b1);
            begin #(48 * 320); enable = 1'b1; end
        join
        exp_q.push_back({BASE, line});
        send_line(line, 1'b1);
        wait_got(200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL midslot_write got=none exp=%h", exp_q[0]); end
        else begin
            got = got_q.pop_front(); exp = exp_q.pop_front();
            if (got !== exp) begin bad++; $display("FAIL midslot_write got=%h exp=%h", got, exp); end
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midslot_busy got=%b exp=1", busy); end
    endtask

    task automatic test_backpressure();
        logic [127:0] line_a, line_b, d0;
        logic [21:0]  a0;
        logic [149:0] got, exp;
        bit ok;
        bit done;
        int unstable;
        line_a = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        line_b = 128'hdead_beef_cafe_f00d_1357_9bdf_2468_ace0;
        unstable = 0;
        done = 1'b0;
        pulse_reset();
        ack_hold = 1'b1;
        enable = 1'b1;
        exp_q.push_back({BASE, line_a});
        send_line(line_a, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 200 && sdram_wr !== 1'b1; i++) @(negedge clk50);
        total++; if (sdram_wr !== 1'b1) begin bad++; $display("FAIL bp_req got=%b exp=1", sdram_wr); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bp_no_ovf got=%b exp=0", overflow); end
        a0 = sdram_addr;
        d0 = sdram_data;
        fork
            begin send_line(line_b, 1'($urandom_range(0, 1))); done = 1'b1; end
            begin
                while (!done) begin
                    @(negedge clk50);
                    if (sdram_wr !== 1'b1 || sdram_addr !== a0 || sdram_data !== d0) unstable++;
                end
            end
        join
        total++; if (unstable !== 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", unstable); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf got=%b exp=1", overflow); end
        ack_hold = 1'b0;
        wait_got(200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_write got=none exp=%h", exp_q[0]); end
        else begin
            got = got_q.pop_front(); exp = exp_q.pop_front();
            if (got !== exp) begin bad++; $display("FAIL bp_write got=%h exp=%h", got, exp); end
        end
        repeat (20) @(negedge clk50);
        total++; if (sdram_wr !== 1'b0) begin bad++; $display("FAIL bp_dropped got=%b exp=0", sdram_wr); end
        total++; if (lines_written !== 22'd1) begin bad++; $display("FAIL bp_lines got=%0d exp=1", lines_written); end
    endtask

    task automatic test_reset_mid_write();
        logic [127:0] line_c, line_d;
        logic [149:0] got, exp;
        bit ok;
        line_c = {$urandom(), $urandom(), $urandom(), $urandom()};
        line_d = {$urandom(), $urandom(), $urandom(), $urandom()};
        ack_hold = 1'b1;
        send_line(line_c, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 200 && sdram_wr !== 1'b1; i++) @(negedge clk50);
        total++; if (sdram_wr !== 1'b1) begin bad++; $display("FAIL rst_pre_req got=%b exp=1", sdram_wr); end
        fork
            send_frame(16'h0f0f, 16'hf0f0, 1'b0);
            begin
                #(40 * 320);
                @(negedge clk50); reset = 1'b1;
                @(negedge clk50); reset = 1'b0;
                total++; if (sdram_wr !== 1'b0) begin bad++; $display("FAIL rst_wr got=%b exp=0", sdram_wr); end
                total++; if (sdram_addr !== BASE) begin bad++; $display("FAIL rst_addr got=%h exp=%h", sdram_addr, BASE); end
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
                total++; if (lines_written !== 22'd0) begin bad++; $display("FAIL rst_lines got=%0d exp=0", lines_written); end
            end
        join
        ack_hold = 1'b0;
        exp_q.push_back({BASE, line_d});
        send_line(line_d, 1'($urandom_range(0, 1)));
        wait_got(200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rst_recapture got=none exp=%h", exp_q[0]); end
        else begin
            got = got_q.pop_front(); exp = exp_q.pop_front();
            if (got !== exp) begin bad++; $display("FAIL rst_recapture got=%h exp=%h", got, exp); end
        end
    endtask

    task automatic test_wrap_and_stop();
        logic [127:0] lines [3];
        logic [21:0]  wrap_addr [3];
        logic [149:0] got, exp;
        wrap_addr[0] = BASE;
        wrap_addr[1] = BASE + 22'd1;
        wrap_addr[2] = BASE;
        pulse_reset();
        enable = 1'b1;
        en_nw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lines[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            exp_q.push_back({wrap_addr[i], lines[i]});
            if (i < 2) exp_nw_q.push_back({wrap_addr[i], lines[i]});
        end
        for (int i = 0; i < 3; i++) send_line(lines[i], 1'($urandom_range(0, 1)));
        repeat (50) @(negedge clk50);
        total++; if (got_q.size() !== 3) begin bad++; $display("FAIL wrap_count got=%0d exp=3", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            got = got_q.pop_front(); exp = exp_q.pop_front();
            total++; if (got !== exp) begin bad++; $display("FAIL wrap_write got=%h exp=%h", got, exp); end
        end
        total++; if (lines_written !== 22'd3) begin bad++; $display("FAIL wrap_lines got=%0d exp=3", lines_written); end
        total++; if (got_nw_q.size() !== 2) begin bad++; $display("FAIL stop_count got=%0d exp=2", got_nw_q.size()); end
        while (got_nw_q.size() > 0 && exp_nw_q.size() > 0) begin
            got = got_nw_q.pop_front(); exp = exp_nw_q.pop_front();
            total++; if (got !== exp) begin bad++; $display("FAIL stop_write got=%h exp=%h", got, exp); end
        end
        total++; if (done_nw !== 1'b1) begin bad++; $display("FAIL stop_done got=%b exp=1", done_nw); end
        total++; if (wr_nw !== 1'b0) begin bad++; $display("FAIL stop_wr got=%b exp=0", wr_nw); end
        total++; if (busy_nw !== 1'b0) begin bad++; $display("FAIL stop_busy got=%b exp=0", busy_nw); end
        total++; if (lw_nw !== 22'd2) begin bad++; $display("FAIL stop_lines got=%0d exp=2", lw_nw); end
        total++; if (ovf_nw !== 1'b0) begin bad++; $display("FAIL stop_ovf got=%b exp=0", ovf_nw); end
    endtask

    // final report
    initial begin
        test_reset();
        test_basic_line();
        test_enable_mid_slot();
        test_backpressure();
        test_reset_mid_write();
        test_wrap_and_stop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
